// File: rtl/cpu_ctrl_pkg.sv
// Package: cpu_ctrl_pkg
// Shared encodings for the multi-cycle CPU control path. The main control
// FSM and ALUControl both import it.
//   - state_t    : 4-bit FSM state encoding (FETCH=0 .. JUMP=12)
//   - OP_*       : 6-bit primary opcodes (instruction bits [31:26])
//   - ALUOP_*    : 2-bit ALU operation class handed to ALUControl
//   - opcode_is_legal() : true for every opcode the control unit sequences
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  function automatic logic opcode_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Interface: main_control_fsm_if
// Bundles the control unit's status inputs and datapath control outputs.
//   master : the control FSM (consumes Opcode/Zero/MemReady, drives controls)
//   slave  : the datapath side (drives status, consumes controls)
interface main_control_fsm_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;

  logic       PCEn;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [1:0] ALUop;
  logic       Illegal;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ALUop, Illegal
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ALUop, Illegal
  );
endinterface

// File: rtl/main_control_fsm.sv
// Module: main_control_fsm
// Multi-cycle main control unit. Walks each instruction through fetch,
// decode, execute, memory and writeback states and decodes the datapath
// enables and mux selects from the current state.
// Ports:
//   clk   : clock, state updates on rising edge
//   rst_n : asynchronous active-low reset, forces FETCH immediately
//   bus   : main_control_fsm_if.master
//           in  Opcode[5:0], Zero, MemReady
//           out PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//               ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], ALUop[1:0], Illegal
module main_control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  main_control_fsm_if.master        bus
);

  state_t state_q, state_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR, and Opcode is held by the IR here.
      S_MEMADR:  state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = bus.MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_IMMWB;
      S_ORIEX:   state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode
  logic       pc_write;
  logic       branch;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       illegal;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [1:0] alu_op;

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALUOP_ADD;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = !opcode_is_legal(bus.Opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      // Strobe stays up for every stall cycle until memory accepts it.
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALUOP_ORI;
      end
      S_IMMWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are qualified by rst_n: the register already reads FETCH
  // during reset, but FETCH would otherwise pass MemReady through.
  assign bus.PCEn     = rst_n & (pc_write | (branch & bus.Zero));
  assign bus.IRWrite  = rst_n & ir_write;
  assign bus.MemWrite = rst_n & mem_write;
  assign bus.RegWrite = rst_n & reg_write;
  assign bus.Illegal  = rst_n & illegal;
  assign bus.IorD     = iord;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.PCSrc    = pc_src;
  assign bus.ALUop    = alu_op;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed testbench for main_control_fsm. Outputs are packed into one
// 15-bit vector {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,
// ALUSrcA,ALUSrcB[1:0],PCSrc[1:0],ALUop[1:0],Illegal} and compared with
// hand-written per-state constants. Inputs change on the falling edge and
// outputs are sampled 1 ns later.
module tb_main_control_fsm;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  main_control_fsm_if bus_if ();

  main_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  //                                PIMIRMRA BB PS AO L
  localparam logic [14:0] V_RESET   = 15'b0000000_0_01_00_00_0;
  localparam logic [14:0] V_FETCH   = 15'b1001000_0_01_00_00_0;
  localparam logic [14:0] V_FSTALL  = 15'b0000000_0_01_00_00_0;
  localparam logic [14:0] V_DECODE  = 15'b0000000_0_11_00_00_0;
  localparam logic [14:0] V_ILLEGAL = 15'b0000000_0_11_00_00_1;
  localparam logic [14:0] V_MEMADR  = 15'b0000000_1_10_00_00_0;
  localparam logic [14:0] V_MEMRD   = 15'b0100000_0_00_00_00_0;
  localparam logic [14:0] V_MEMWB   = 15'b0000011_0_00_00_00_0;
  localparam logic [14:0] V_MEMWR   = 15'b0110000_0_00_00_00_0;
  localparam logic [14:0] V_EXECUTE = 15'b0000000_1_00_00_10_0;
  localparam logic [14:0] V_ALUWB   = 15'b0000101_0_00_00_00_0;
  localparam logic [14:0] V_BR_TAKE = 15'b1000000_1_00_01_01_0;
  localparam logic [14:0] V_BR_NOT  = 15'b0000000_1_00_01_01_0;
  localparam logic [14:0] V_ADDIEX  = 15'b0000000_1_10_00_00_0;
  localparam logic [14:0] V_ORIEX   = 15'b0000000_1_10_00_11_0;
  localparam logic [14:0] V_IMMWB   = 15'b0000001_0_00_00_00_0;
  localparam logic [14:0] V_JUMP    = 15'b1000000_0_00_10_00_0;

  function automatic logic [14:0] outs();
    return {bus_if.PCEn, bus_if.IorD, bus_if.MemWrite, bus_if.IRWrite,
            bus_if.RegDst, bus_if.MemtoReg, bus_if.RegWrite, bus_if.ALUSrcA,
            bus_if.ALUSrcB, bus_if.PCSrc, bus_if.ALUop, bus_if.Illegal};
  endfunction

  // Sample outputs 1 ns into the low phase, then move to the next falling edge.
  task automatic cyc(input string tag, input logic [14:0] expv);
    logic [14:0] obs;
    #1;
    obs = outs();
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
    $display("step %-14s outs=%b exp=%b", tag, obs, expv);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n           = 1'b0;
    bus_if.MemReady = 1'b1;
    bus_if.Opcode   = 6'b000000;
    bus_if.Zero     = 1'b0;
    @(negedge clk);
    cyc("reset", V_RESET);
    rst_n = 1'b1;

    // lw, MemReady=1: five cycles
    bus_if.Opcode = 6'b100011;
    cyc("lw.fetch", V_FETCH);
    cyc("lw.decode", V_DECODE);
    cyc("lw.memadr", V_MEMADR);
    cyc("lw.memrd", V_MEMRD);
    cyc("lw.memwb", V_MEMWB);

    // R-type
    bus_if.Opcode = 6'b000000;
    cyc("r.fetch", V_FETCH);
    cyc("r.decode", V_DECODE);
    cyc("r.execute", V_EXECUTE);
    cyc("r.aluwb", V_ALUWB);

    // beq taken
    bus_if.Opcode = 6'b000100;
    cyc("beq1.fetch", V_FETCH);
    cyc("beq1.decode", V_DECODE);
    bus_if.Zero = 1'b1;
    cyc("beq1.branch", V_BR_TAKE);
    bus_if.Zero = 1'b0;

    // beq not taken
    cyc("beq0.fetch", V_FETCH);
    cyc("beq0.decode", V_DECODE);
    cyc("beq0.branch", V_BR_NOT);

    // FETCH stall for three cycles, then addi
    bus_if.Opcode   = 6'b001000;
    bus_if.MemReady = 1'b0;
    cyc("stall.f1", V_FSTALL);
    cyc("stall.f2", V_FSTALL);
    cyc("stall.f3", V_FSTALL);
    bus_if.MemReady = 1'b1;
    cyc("addi.fetch", V_FETCH);
    cyc("addi.decode", V_DECODE);
    cyc("addi.ex", V_ADDIEX);
    cyc("addi.wb", V_IMMWB);

    // ori
    bus_if.Opcode = 6'b001101;
    cyc("ori.fetch", V_FETCH);
    cyc("ori.decode", V_DECODE);
    cyc("ori.ex", V_ORIEX);
    cyc("ori.wb", V_IMMWB);

    // j
    bus_if.Opcode = 6'b000010;
    cyc("j.fetch", V_FETCH);
    cyc("j.decode", V_DECODE);
    cyc("j.jump", V_JUMP);

    // sw with one stall cycle in MEMWR
    bus_if.Opcode = 6'b101011;
    cyc("sw.fetch", V_FETCH);
    cyc("sw.decode", V_DECODE);
    cyc("sw.memadr", V_MEMADR);
    bus_if.MemReady = 1'b0;
    cyc("sw.memwr0", V_MEMWR);
    bus_if.MemReady = 1'b1;
    cyc("sw.memwr1", V_MEMWR);

    // Illegal opcode
    bus_if.Opcode = 6'b111111;
    cyc("ill.fetch", V_FETCH);
    cyc("ill.decode", V_ILLEGAL);
    bus_if.Opcode = 6'b000010;
    cyc("ill.after", V_FETCH);
    cyc("ill.j.decode", V_DECODE);
    cyc("ill.j.jump", V_JUMP);

    // lw with one MEMRD stall, then reset mid-MEMRD
    bus_if.Opcode = 6'b100011;
    cyc("lwr.fetch", V_FETCH);
    cyc("lwr.decode", V_DECODE);
    cyc("lwr.memadr", V_MEMADR);
    bus_if.MemReady = 1'b0;
    cyc("lwr.memrd0", V_MEMRD);
    bus_if.MemReady = 1'b1;
    rst_n = 1'b0;                 // no clock edge before the next sample
    cyc("lwr.rst_async", V_RESET);
    cyc("lwr.rst_hold", V_RESET);
    rst_n = 1'b1;
    bus_if.Opcode = 6'b000000;
    cyc("post.fetch", V_FETCH);
    cyc("post.decode", V_DECODE);
    cyc("post.execute", V_EXECUTE);
    cyc("post.aluwb", V_ALUWB);
    cyc("post.fetch2", V_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
